q16_link_arbiter: RTL and testbench

Round-robin arbiter that shares one packed 32-bit Q16 operand link among N_REQ requesters. Each requester presents a 16-bit pair (a, b). The arbiter packs the granted pair into one strobed link word, waits for the nonzero result word coming back, and returns that result to the granted requester only. It sits between the requester-side engines and the pack/unpack link stage. It is the single sequencer for that link.

---
 rtl/q16_arb_pkg.sv | 17 +
 rtl/q16_link_arbiter_if.sv | 27 ++
 rtl/q16_rr_pick.sv | 27 ++
 rtl/q16_link_arbiter.sv | 119 +++++++++++
 tb/tb_q16_link_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/q16_arb_pkg.sv
// rtl/q16_arb_pkg.sv - shared types, widths and link packing for the Q16 link arbiter
package q16_arb_pkg;
    localparam int LINK_W         = 32;
    localparam int HALF_W         = 16;
    localparam int LINK_VALID_BIT = 31;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

    // Bit 31 carries the strobe, so the top bit of a has no room on the link.
    function automatic logic [LINK_W-1:0] pack_link(input logic [HALF_W-1:0] a,
                                                    input logic [HALF_W-1:0] b);
        logic [LINK_W-1:0] word;
        word                 = {1'b0, a[HALF_W-2:0], b};
        word[LINK_VALID_BIT] = 1'b1;
        return word;
    endfunction
endpackage

// File: rtl/q16_link_arbiter_if.sv
// rtl/q16_link_arbiter_if.sv - requester and link signals of the Q16 link arbiter
interface q16_link_arbiter_if
    import q16_arb_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]        req;
    logic [HALF_W*N_REQ-1:0] req_a;
    logic [HALF_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]        gnt;
    logic [LINK_W-1:0]       link_out;
    logic [LINK_W-1:0]       link_in;
    logic [N_REQ-1:0]        resp_valid;
    logic [LINK_W-1:0]       resp_data;
    logic                    resp_err;
    logic                    busy;

    modport master (
        input  req, req_a, req_b, link_in,
        output gnt, link_out, resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        output req, req_a, req_b, link_in,
        input  gnt, link_out, resp_valid, resp_data, resp_err, busy
    );
endinterface

// File: rtl/q16_rr_pick.sv
// rtl/q16_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module q16_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        int cand;
        cand = 0;
        win  = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                    = 1'b1;
                idx                    = cand[IDX_W-1:0];
                win[cand[IDX_W-1:0]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/q16_link_arbiter.sv
// rtl/q16_link_arbiter.sv - round-robin sequencer for the shared Q16 operand link
// Optional WAIT timeout built when Q16_ARB_TIMEOUT_EN is defined.
module q16_link_arbiter
    import q16_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    q16_link_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    idx_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [LINK_W-1:0]   link_q;
    logic [N_REQ-1:0]    resp_valid_q;
    logic [LINK_W-1:0]   resp_data_q;
    logic                resp_err_q;
    logic                busy_q;

    logic [N_REQ-1:0]    pick_win;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [HALF_W-1:0]   a_sel;
    logic [HALF_W-1:0]   b_sel;
    logic                tmo_hit;

    q16_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign a_sel = bus.req_a[pick_idx*HALF_W +: HALF_W];
    assign b_sel = bus.req_b[pick_idx*HALF_W +: HALF_W];

`ifdef Q16_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Counts completed WAIT cycles; reaching TIMEOUT-1 means this is the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 16'd1;
        else
            tmo_cnt <= '0;
    end

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            idx_q        <= '0;
            gnt_q        <= '0;
            link_q       <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx_q  <= pick_idx;
                        gnt_q  <= pick_win;
                        link_q <= pack_link(a_sel, b_sel);
                        busy_q <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    link_q <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // A real result on the same edge as the timeout wins.
                    if (bus.link_in != '0) begin
                        resp_data_q  <= bus.link_in;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= gnt_q;
                        state        <= DONE;
                    end else if (tmo_hit) begin
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= gnt_q;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    gnt_q  <= '0;
                    ptr    <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.link_out   = link_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_q16_link_arbiter.sv
// tb/tb_q16_link_arbiter.sv - directed self-checking bench for q16_link_arbiter
module tb_q16_link_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    q16_link_arbiter_if #(.N_REQ(4)) bus ();

    q16_link_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  32'(bus.gnt),        32'h0);
        chk({tag, "_link"}, bus.link_out,        32'h0);
        chk({tag, "_rv"},   32'(bus.resp_valid), 32'h0);
        chk({tag, "_rd"},   bus.resp_data,       32'h0);
        chk({tag, "_err"},  32'(bus.resp_err),   32'h0);
        chk({tag, "_busy"}, 32'(bus.busy),       32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Starts in IDLE at a negedge with req already set; result returned on WAIT cycle 1.
    task automatic run_txn(input string tag, input int idx, input logic [31:0] exp_link,
                           input logic [31:0] result);
        step();
        chk({tag, "_gnt"},  32'(bus.gnt), 32'(4'b0001 << idx));
        chk({tag, "_link"}, bus.link_out, exp_link);
        step();
        bus.link_in = result;
        step();
        bus.link_in = 32'h0;
        chk({tag, "_rv"}, 32'(bus.resp_valid), 32'(4'b0001 << idx));
        chk({tag, "_rd"}, bus.resp_data, result);
        step();
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b0;
        bus.req     = '0;
        bus.req_a   = '0;
        bus.req_b   = '0;
        bus.link_in = '0;
        step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();

        // Single request, result on second WAIT cycle; req dropped after grant.
        set_ops(0, 16'h0012, 16'h3456);
        bus.req = 4'b0001;
        step();
        chk("t1_link",  bus.link_out, 32'h8012_3456);
        chk("t1_gnt",   32'(bus.gnt), 32'h1);
        chk("t1_busy",  32'(bus.busy), 32'h1);
        bus.req = 4'b0000;
        step();
        chk("t1_link0", bus.link_out, 32'h0);
        chk("t1_norv",  32'(bus.resp_valid), 32'h0);
        step();
        bus.link_in = 32'h0001_0002;
        step();
        bus.link_in = 32'h0;
        chk("t1_rv",    32'(bus.resp_valid), 32'h1);
        chk("t1_rd",    bus.resp_data, 32'h0001_0002);
        chk("t1_err",   32'(bus.resp_err), 32'h0);
        step();
        chk("t1_rvoff", 32'(bus.resp_valid), 32'h0);
        chk("t1_gnt0",  32'(bus.gnt), 32'h0);
        chk("t1_idle",  32'(bus.busy), 32'h0);
        chk("t1_hold",  bus.resp_data, 32'h0001_0002);

        // All four request with pointer back at 0.
        do_reset();
        set_ops(0, 16'h1111, 16'h0001);
        set_ops(1, 16'h2222, 16'h0002);
        set_ops(2, 16'h3333, 16'h0003);
        set_ops(3, 16'h4444, 16'h0004);
        bus.req = 4'b1111;
        run_txn("t2_0", 0, 32'h9111_0001, 32'h0000_0100);
        run_txn("t2_1", 1, 32'hA222_0002, 32'h0000_0101);
        run_txn("t2_2", 2, 32'hB333_0003, 32'h0000_0102);
        run_txn("t2_3", 3, 32'hC444_0004, 32'h0000_0103);

        // Fairness between 0 and 2; pointer is 0 again here.
        bus.req = 4'b0101;
        run_txn("t3_a", 0, 32'h9111_0001, 32'h0000_0200);
        run_txn("t3_b", 2, 32'hB333_0003, 32'h0000_0201);
        run_txn("t3_c", 0, 32'h9111_0001, 32'h0000_0202);
        run_txn("t3_d", 2, 32'hB333_0003, 32'h0000_0203);

        // a[15] dropped; link_in during ISSUE must not complete the transaction.
        set_ops(1, 16'hFFFF, 16'h0000);
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        chk("t4_link", bus.link_out, 32'hFFFF_0000);
        chk("t4_gnt",  32'(bus.gnt), 32'h2);
        bus.link_in = 32'hDEAD_BEEF;
        step();
        chk("t4_norv", 32'(bus.resp_valid), 32'h0);
        bus.link_in = 32'h0000_0055;
        step();
        bus.link_in = 32'h0;
        chk("t4_rv", 32'(bus.resp_valid), 32'h2);
        chk("t4_rd", bus.resp_data, 32'h0000_0055);
        step();

`ifdef Q16_ARB_TIMEOUT_EN
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        chk("t5_gnt", 32'(bus.gnt), 32'h4);
        for (int i = 0; i < 8; i++) step();
        chk("t5_wait8_rv",   32'(bus.resp_valid), 32'h0);
        chk("t5_wait8_busy", 32'(bus.busy), 32'h1);
        step();
        chk("t5_rv",  32'(bus.resp_valid), 32'h4);
        chk("t5_err", 32'(bus.resp_err), 32'h1);
        chk("t5_rd",  bus.resp_data, 32'h0);
        step();
        chk("t5_idle", 32'(bus.busy), 32'h0);
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        step();
        step();
`else
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        chk("t5_gnt", 32'(bus.gnt), 32'h4);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_nodone", 32'(bus.resp_valid), 32'h0);
        end
        chk("t5_busy", 32'(bus.busy), 32'h1);
`endif

        // Async reset while in WAIT.
        chk("t6_inwait", 32'(bus.busy), 32'h1);
        #2 rst = 1'b0;
        #1 chk_all_zero("t6_async");
        bus.link_in = 32'h0000_0077;
        step();
        step();
        chk("t6_norv", 32'(bus.resp_valid), 32'h0);
        bus.link_in = 32'h0;
        rst = 1'b1;
        set_ops(3, 16'h0ABC, 16'h1234);
        bus.req = 4'b1000;
        run_txn("t6_r3", 3, 32'h8ABC_1234, 32'h0000_0300);
        bus.req = 4'b0000;
        step();
        chk("t6_idle", 32'(bus.busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
